// File: rtl/hazard_detection_unit_pkg.sv
`default_nettype none
// ============================================================================
// Module      : hazard_detection_unit_pkg
// Description : Shared types for the hazard detection unit: FSM state
//               encoding, register-address width and the destination tag
//               carried through the ID/EX, EX/MEM and MEM/WB stages.
// Revision    : 1.0 - initial release
// ============================================================================
package hazard_detection_unit_pkg;

  localparam int REG_ADDR_W = 5;

  typedef enum logic [0:0] {
    ST_RUN    = 1'b0,
    ST_LSTALL = 1'b1
  } state_t;

  typedef struct packed {
    logic [REG_ADDR_W-1:0] rd;
    logic                  regwrite;
    logic                  memread;
  } tag_t;

  localparam tag_t c_TAG_NONE = '{rd: '0, regwrite: 1'b0, memread: 1'b0};

endpackage : hazard_detection_unit_pkg
`default_nettype wire

// File: rtl/hazard_detection_unit_tag_pipe.sv
`default_nettype none
// ============================================================================
// Module      : hazard_tag_pipe
// Description : Three-stage shift register of destination tags mirroring
//               the ID/EX, EX/MEM and MEM/WB pipeline registers.
// Ports       : clk, rst      - clock, asynchronous active-high reset
//               i_en          - advance enable (low while the pipe is frozen)
//               i_id_tag      - tag entering ID/EX (already bubbled/flushed)
//               o_id_ex       - tag held in ID/EX
//               o_ex_mem      - tag held in EX/MEM
//               o_mem_wb      - tag held in MEM/WB
// Revision    : 1.0 - initial release
// ============================================================================
import hazard_detection_unit_pkg::*;

module hazard_tag_pipe (
  input  logic clk,
  input  logic rst,
  input  logic i_en,
  input  tag_t i_id_tag,
  output tag_t o_id_ex,
  output tag_t o_ex_mem,
  output tag_t o_mem_wb
);

  tag_t r_id_ex;
  tag_t r_ex_mem;
  tag_t r_mem_wb;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_id_ex  <= c_TAG_NONE;
      r_ex_mem <= c_TAG_NONE;
      r_mem_wb <= c_TAG_NONE;
    end else if (i_en) begin
      r_mem_wb <= r_ex_mem;
      r_ex_mem <= r_id_ex;
      r_id_ex  <= i_id_tag;
    end
  end

  assign o_id_ex  = r_id_ex;
  assign o_ex_mem = r_ex_mem;
  assign o_mem_wb = r_mem_wb;

endmodule : hazard_tag_pipe
`default_nettype wire

// File: rtl/hazard_detection_unit.sv
`default_nettype none
// ============================================================================
// Module      : hazard_detection_unit
// Description : Load-use hazard detection and pipeline control for a 5-stage
//               RV32 core. Tracks destination tags for in-flight instructions
//               and exports the EX/MEM and MEM/WB tags for the bypass muxes.
// Ports       : clk, rst                 - clock, async active-high reset
//               IF_ID_rs1/rs2, use_rs1/2 - source operands of the ID instr
//               ID_rd/regwrite/memread   - destination info of the ID instr
//               branch_taken             - taken branch resolved in EX
//               mem_stall                - D-cache not ready
//               stall/bubble/flush/freeze- pipeline control (combinational)
//               EX_MEM_*, MEM_WB_*       - tags for the bypass control
//               stall_cycles             - saturating load-use stall count
// Revision    : 1.0 - initial release
// ============================================================================
import hazard_detection_unit_pkg::*;

module hazard_detection_unit #(
  parameter int LOAD_USE_BUBBLES = 1,
  parameter int PERF_W           = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [REG_ADDR_W-1:0] IF_ID_rs1,
  input  logic [REG_ADDR_W-1:0] IF_ID_rs2,
  input  logic                  IF_ID_use_rs1,
  input  logic                  IF_ID_use_rs2,
  input  logic [REG_ADDR_W-1:0] ID_rd,
  input  logic                  ID_regwrite,
  input  logic                  ID_memread,
  input  logic                  branch_taken,
  input  logic                  mem_stall,
  output logic                  stall,
  output logic                  bubble,
  output logic                  flush,
  output logic                  freeze,
  output logic [REG_ADDR_W-1:0] EX_MEM_rd,
  output logic                  EX_MEM_regwrite,
  output logic [REG_ADDR_W-1:0] MEM_WB_rd,
  output logic                  MEM_WB_regwrite,
  output logic [PERF_W-1:0]     stall_cycles
);

  localparam int         c_CNT_W    = 2;
  localparam bit         c_MULTI    = (LOAD_USE_BUBBLES > 1);
  // Extra LSTALL cycles after the first stall cycle, minus one (cnt==0 is the last).
  localparam logic [1:0] c_CNT_INIT = c_MULTI ? c_CNT_W'(LOAD_USE_BUBBLES - 2) : 2'd0;

  state_t               r_state;
  state_t               w_state_nxt;
  logic [c_CNT_W-1:0]   r_cnt;
  logic [c_CNT_W-1:0]   w_cnt_nxt;
  logic [PERF_W-1:0]    r_stall_cycles;

  logic                 w_stall;
  logic                 w_bubble;
  logic                 w_flush;
  logic                 w_freeze;
  logic                 w_hazard;

  tag_t                 w_id_tag;
  tag_t                 w_id_ex;
  tag_t                 w_ex_mem;
  tag_t                 w_mem_wb;
  logic                 w_unused;

  assign w_freeze = mem_stall & ~rst;

  assign w_hazard = w_id_ex.memread && (w_id_ex.rd != '0) &&
                    ((IF_ID_use_rs1 && (w_id_ex.rd == IF_ID_rs1)) ||
                     (IF_ID_use_rs2 && (w_id_ex.rd == IF_ID_rs2)));

  // Priority: reset > mem_stall > branch_taken > load-use / LSTALL.
  always_comb begin
    w_stall     = 1'b0;
    w_bubble    = 1'b0;
    w_flush     = 1'b0;
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    if (!rst && !mem_stall) begin
      if (branch_taken) begin
        // The ID instruction is squashed, so its load-use check is moot.
        w_flush     = 1'b1;
        w_bubble    = 1'b1;
        w_state_nxt = ST_RUN;
      end else begin
        case (r_state)
          ST_RUN: begin
            if (w_hazard) begin
              w_stall  = 1'b1;
              w_bubble = 1'b1;
              if (c_MULTI) begin
                w_state_nxt = ST_LSTALL;
                w_cnt_nxt   = c_CNT_INIT;
              end
            end
          end
          ST_LSTALL: begin
            w_stall  = 1'b1;
            w_bubble = 1'b1;
            if (r_cnt == '0) begin
              w_state_nxt = ST_RUN;
            end else begin
              w_cnt_nxt = r_cnt - 2'd1;
            end
          end
          default: w_state_nxt = ST_RUN;
        endcase
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_RUN;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  // w_stall is already low while frozen, so no explicit freeze term is needed.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_stall_cycles <= '0;
    end else if (w_stall && (r_stall_cycles != '1)) begin
      r_stall_cycles <= r_stall_cycles + PERF_W'(1);
    end
  end

  always_comb begin
    w_id_tag = c_TAG_NONE;
    if (!(w_bubble || w_flush)) begin
      w_id_tag.rd       = ID_rd;
      w_id_tag.regwrite = ID_regwrite;
      w_id_tag.memread  = ID_memread;
    end
  end

  hazard_tag_pipe u_tag_pipe (
    .clk      (clk),
    .rst      (rst),
    .i_en     (~w_freeze),
    .i_id_tag (w_id_tag),
    .o_id_ex  (w_id_ex),
    .o_ex_mem (w_ex_mem),
    .o_mem_wb (w_mem_wb)
  );

  // Only ID/EX needs the load flag; later stages carry it for symmetry.
  assign w_unused = ^{w_ex_mem.memread, w_mem_wb.memread};

  assign stall           = w_stall;
  assign bubble          = w_bubble;
  assign flush           = w_flush;
  assign freeze          = w_freeze;
  assign EX_MEM_rd       = w_ex_mem.rd;
  assign EX_MEM_regwrite = w_ex_mem.regwrite;
  assign MEM_WB_rd       = w_mem_wb.rd;
  assign MEM_WB_regwrite = w_mem_wb.regwrite;
  assign stall_cycles    = r_stall_cycles;

endmodule : hazard_detection_unit
`default_nettype wire

// File: tb/tb_hazard_detection_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_hazard_detection_unit
// Description : Self-checking bench. Three DUT copies (1, 2 and 3 load-use
//               bubbles; the 2-bubble copy has a 4-bit perf counter) share
//               one stimulus stream and are compared against a per-copy
//               reference model built from stall-cycles-remaining counts.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_hazard_detection_unit;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst;
  logic [4:0] rs1, rs2, id_rd;
  logic       u1, u2, id_rw, id_mr, br, ms;

  logic        d_stall  [3];
  logic        d_bubble [3];
  logic        d_flush  [3];
  logic        d_freeze [3];
  logic        d_exrw   [3];
  logic        d_wbrw   [3];
  logic [4:0]  d_exrd   [3];
  logic [4:0]  d_wbrd   [3];
  logic [15:0] d_sc     [3];

  generate
    for (genvar g = 0; g < 3; g++) begin : g_dut
      localparam int LUB = g + 1;
      localparam int PW  = (g == 1) ? 4 : 16;
      logic [PW-1:0] sc;
      hazard_detection_unit #(.LOAD_USE_BUBBLES(LUB), .PERF_W(PW)) u_dut (
        .clk(clk), .rst(rst),
        .IF_ID_rs1(rs1), .IF_ID_rs2(rs2),
        .IF_ID_use_rs1(u1), .IF_ID_use_rs2(u2),
        .ID_rd(id_rd), .ID_regwrite(id_rw), .ID_memread(id_mr),
        .branch_taken(br), .mem_stall(ms),
        .stall(d_stall[g]), .bubble(d_bubble[g]), .flush(d_flush[g]),
        .freeze(d_freeze[g]),
        .EX_MEM_rd(d_exrd[g]), .EX_MEM_regwrite(d_exrw[g]),
        .MEM_WB_rd(d_wbrd[g]), .MEM_WB_regwrite(d_wbrw[g]),
        .stall_cycles(sc)
      );
      assign d_sc[g] = 16'(sc);
    end
  endgenerate

  // ---------------- reference model ----------------
  int lub  [3] = '{1, 2, 3};
  int smax [3] = '{65535, 15, 65535};
  int m_rd [3][3];   // [copy][0=ID_EX,1=EX_MEM,2=MEM_WB]
  int m_rw [3][3];
  int m_mr [3][3];
  int m_left [3];    // stall cycles still owed after the current one
  int m_sc [3];
  bit e_st [3], e_bu [3], e_fl [3], e_hz [3];

  int n_chk  = 0;
  int n_fail = 0;

  task automatic model_reset();
    for (int i = 0; i < 3; i++) begin
      for (int s = 0; s < 3; s++) begin
        m_rd[i][s] = 0; m_rw[i][s] = 0; m_mr[i][s] = 0;
      end
      m_left[i] = 0;
      m_sc[i]   = 0;
    end
  endtask

  task automatic chk(input string t, input int i, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s[lub=%0d] observed=%0h expected=%0h", t, i + 1, obs, exp);
    end
  endtask

  task automatic check_all();
    for (int i = 0; i < 3; i++) begin
      e_hz[i] = (m_mr[i][0] != 0) && (m_rd[i][0] != 0) &&
                ((u1 && (m_rd[i][0] == int'(rs1))) || (u2 && (m_rd[i][0] == int'(rs2))));
      e_st[i] = 1'b0; e_bu[i] = 1'b0; e_fl[i] = 1'b0;
      if (!rst && !ms) begin
        if (br) begin
          e_fl[i] = 1'b1; e_bu[i] = 1'b1;
        end else if (m_left[i] > 0 || e_hz[i]) begin
          e_st[i] = 1'b1; e_bu[i] = 1'b1;
        end
      end
      chk("stall",  i, 32'(d_stall[i]),  32'(e_st[i]));
      chk("bubble", i, 32'(d_bubble[i]), 32'(e_bu[i]));
      chk("flush",  i, 32'(d_flush[i]),  32'(e_fl[i]));
      chk("freeze", i, 32'(d_freeze[i]), 32'(ms & ~rst));
      chk("ex_mem_rd", i, 32'(d_exrd[i]), m_rd[i][1]);
      chk("ex_mem_rw", i, 32'(d_exrw[i]), m_rw[i][1]);
      chk("mem_wb_rd", i, 32'(d_wbrd[i]), m_rd[i][2]);
      chk("mem_wb_rw", i, 32'(d_wbrw[i]), m_rw[i][2]);
      chk("stall_cycles", i, 32'(d_sc[i]), m_sc[i]);
    end
  endtask

  task automatic model_step();
    if (rst) begin
      model_reset();
    end else if (!ms) begin
      for (int i = 0; i < 3; i++) begin
        if (e_st[i] && m_sc[i] < smax[i]) m_sc[i]++;
        if (br)               m_left[i] = 0;
        else if (m_left[i] > 0) m_left[i]--;
        else if (e_hz[i])     m_left[i] = lub[i] - 1;
        for (int s = 2; s > 0; s--) begin
          m_rd[i][s] = m_rd[i][s-1]; m_rw[i][s] = m_rw[i][s-1]; m_mr[i][s] = m_mr[i][s-1];
        end
        if (e_bu[i] || e_fl[i]) begin
          m_rd[i][0] = 0; m_rw[i][0] = 0; m_mr[i][0] = 0;
        end else begin
          m_rd[i][0] = int'(id_rd); m_rw[i][0] = int'(id_rw); m_mr[i][0] = int'(id_mr);
        end
      end
    end
  endtask

  // One clock: drive at negedge, check 1 ns later, advance model at posedge.
  task automatic cyc(input logic [4:0] a1, input logic [4:0] a2, input logic v1, input logic v2,
                     input logic [4:0] d, input logic w, input logic m,
                     input logic b, input logic s, input logic r);
    @(negedge clk);
    rs1 = a1; rs2 = a2; u1 = v1; u2 = v2;
    id_rd = d; id_rw = w; id_mr = m; br = b; ms = s; rst = r;
    if (r) model_reset();
    #1 check_all();
    @(posedge clk);
    model_step();
  endtask

  task automatic nop(input int n);
    repeat (n) cyc(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic ld(input logic [4:0] d);
    cyc(5'd0, 5'd0, 1'b0, 1'b0, d, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic use_rs1(input logic [4:0] r, input int n);
    repeat (n) cyc(r, 5'd0, 1'b1, 1'b0, 5'd6, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    rst = 1'b1; rs1 = '0; rs2 = '0; u1 = 0; u2 = 0;
    id_rd = '0; id_rw = 0; id_mr = 0; br = 0; ms = 0;
    model_reset();

    // Reset state
    repeat (2) cyc(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    nop(2);

    // Basic load-use: lw x5 then add reading x5
    ld(5'd5); use_rs1(5'd5, 3); nop(3);

    // Load to x0 never stalls
    ld(5'd0); use_rs1(5'd0, 2); nop(3);

    // rs2 matches but is not read
    ld(5'd7);
    repeat (2) cyc(5'd1, 5'd7, 1'b1, 1'b0, 5'd6, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    nop(3);

    // rs2 matches and is read
    ld(5'd7);
    repeat (3) cyc(5'd1, 5'd7, 1'b1, 1'b1, 5'd6, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    nop(3);

    // mem_stall for 3 cycles in the middle of a load-use stall
    ld(5'd9); use_rs1(5'd9, 2);
    repeat (3) cyc(5'd9, 5'd0, 1'b1, 1'b0, 5'd6, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
    use_rs1(5'd9, 2); nop(3);

    // branch coincident with load-use hazard
    ld(5'd4);
    cyc(5'd4, 5'd0, 1'b1, 1'b0, 5'd6, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    nop(2);

    // branch coincident with mem_stall, then branch alone
    ld(5'd4);
    cyc(5'd4, 5'd0, 1'b1, 1'b0, 5'd6, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
    cyc(5'd4, 5'd0, 1'b1, 1'b0, 5'd6, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    nop(3);

    // branch arriving during LSTALL
    ld(5'd11); use_rs1(5'd11, 1);
    cyc(5'd11, 5'd0, 1'b1, 1'b0, 5'd6, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    nop(3);

    // Reset asserted mid-stall
    ld(5'd3); use_rs1(5'd3, 1);
    repeat (2) cyc(5'd3, 5'd0, 1'b1, 1'b0, 5'd6, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
    nop(2);

    // Drive the 4-bit counter into saturation
    repeat (12) begin
      ld(5'd8); use_rs1(5'd8, 3);
    end
    nop(3);

    // Randomized traffic
    for (int k = 0; k < 400; k++) begin
      cyc(5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
          1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
          5'($urandom_range(0, 7)), 1'($urandom_range(0, 1)),
          1'($urandom_range(0, 9) < 4),
          1'($urandom_range(0, 9) == 0),
          1'($urandom_range(0, 9) == 0),
          1'($urandom_range(0, 99) == 0));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule : tb_hazard_detection_unit
`default_nettype wire
